// File: rtl/keycode_action_scanner.sv
// Avalon-MM keyboard report scanner: stages a 6-slot HID report, snapshots it on commit,
// scans one slot per clock against the key map and publishes the action bitmap atomically.
module keycode_action_scanner #(
  parameter logic [7:0] KEY_P1_UP    = 8'h1A,
  parameter logic [7:0] KEY_P1_LEFT  = 8'h04,
  parameter logic [7:0] KEY_P1_DOWN  = 8'h16,
  parameter logic [7:0] KEY_P1_RIGHT = 8'h07,
  parameter logic [7:0] KEY_P1_FIRE  = 8'h2C,
  parameter logic [7:0] KEY_P2_UP    = 8'h52,
  parameter logic [7:0] KEY_P2_LEFT  = 8'h50,
  parameter logic [7:0] KEY_P2_DOWN  = 8'h51,
  parameter logic [7:0] KEY_P2_RIGHT = 8'h4F,
  parameter logic [7:0] KEY_P2_FIRE  = 8'h28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  actions,
  output logic        frame_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [7:0] KEY_MAP [10] = '{
    KEY_P1_UP, KEY_P1_LEFT, KEY_P1_DOWN, KEY_P1_RIGHT, KEY_P1_FIRE,
    KEY_P2_UP, KEY_P2_LEFT, KEY_P2_DOWN, KEY_P2_RIGHT, KEY_P2_FIRE
  };

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic [31:0] stage0_reg;
  logic [15:0] stage1_reg;
  logic [47:0] snap_reg;
  logic [9:0]  acc_reg;
  logic        abort_reg;
  logic        err_reg;
  logic        pending_reg;
  logic        commit_req_reg;

  logic        wr;
  logic        wr_commit;
  logic        wr_clear;
  logic [7:0]  slot_byte;
  logic [9:0]  key_hit;

  assign wr        = chipselect & ~write_n;
  assign wr_commit = wr && (address == 2'd2);
  assign wr_clear  = wr && (address == 2'd3) && writedata[0];
  assign slot_byte = snap_reg[{idx_reg, 3'b000} +: 8];

  // The accepted commit is held one cycle in commit_req_reg, which counts as busy.
  assign busy = (state_reg != IDLE) || commit_req_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_key
      assign key_hit[gi] = (slot_byte == KEY_MAP[gi]);
    end
  endgenerate

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = stage0_reg;
      2'd1:    readdata = {16'd0, stage1_reg};
      2'd2:    readdata = 32'd0;
      default: readdata = {12'd0, actions, 6'd0, pending_reg, err_reg, busy, 1'b0};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= 3'd0;
      stage0_reg     <= 32'd0;
      stage1_reg     <= 16'd0;
      snap_reg       <= 48'd0;
      acc_reg        <= 10'd0;
      abort_reg      <= 1'b0;
      err_reg        <= 1'b0;
      pending_reg    <= 1'b0;
      commit_req_reg <= 1'b0;
      actions        <= 10'd0;
      frame_valid    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;

      if (wr && address == 2'd0) stage0_reg <= writedata;
      if (wr && address == 2'd1) stage1_reg <= writedata[15:0];
      if (wr_clear) err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (commit_req_reg || pending_reg) begin
            snap_reg       <= {stage1_reg, stage0_reg};
            acc_reg        <= 10'd0;
            abort_reg      <= 1'b0;
            idx_reg        <= 3'd0;
            commit_req_reg <= 1'b0;
            pending_reg    <= 1'b0;
            state_reg      <= SCAN;
          end
        end
        SCAN: begin
          if (slot_byte == 8'h01)
            abort_reg <= 1'b1;
          else if (slot_byte != 8'h00)
            acc_reg <= acc_reg | key_hit;
          if (idx_reg == 3'd5)
            state_reg <= COMMIT;
          else
            idx_reg <= idx_reg + 3'd1;
        end
        COMMIT: begin
          // Placed after the clear so an abort on the same edge leaves err set.
          if (!abort_reg) begin
            actions     <= acc_reg;
            frame_valid <= 1'b1;
          end else begin
            err_reg <= 1'b1;
          end
          if (pending_reg) begin
            snap_reg    <= {stage1_reg, stage0_reg};
            acc_reg     <= 10'd0;
            abort_reg   <= 1'b0;
            idx_reg     <= 3'd0;
            pending_reg <= 1'b0;
            state_reg   <= SCAN;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // New commits are evaluated last so they are never lost to the clears above.
      if (wr_commit) begin
        if (!busy)
          commit_req_reg <= 1'b1;
        else if (!pending_reg)
          pending_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keycode_action_scanner.sv
// Directed bench for keycode_action_scanner: latency, mapping, abort, pending, reset and register map.
module tb_keycode_action_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  actions;
  logic        frame_valid;
  logic        busy;

  int checks = 0;
  int failures = 0;

  keycode_action_scanner dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .actions(actions), .frame_valid(frame_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Commit at E0, then sample after E0..E15 counting busy cycles and frame_valid pulses.
  task automatic do_frame(input logic [31:0] s0, input logic [31:0] s1,
                          output int busy_cnt, output int fv_cnt, output int fv_edge);
    busy_cnt = 0; fv_cnt = 0; fv_edge = -1;
    av_write(2'd0, s0);
    av_write(2'd1, s1);
    av_write(2'd2, 32'd0);
    for (int k = 0; k < 16; k++) begin
      if (busy) busy_cnt++;
      if (frame_valid) begin fv_cnt++; fv_edge = k; end
      step();
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    checks++;
    if (actions !== 10'd0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs actions=%h fv=%b busy=%b required 000/0/0", actions, frame_valid, busy);
    end
    av_read(2'd3, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL reset_status got=%h required=00000000", r); end
    av_read(2'd0, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL reset_stage0 got=%h required=00000000", r); end
    $display("test_reset done");
  endtask

  task automatic check_frame(input string name, input logic [31:0] s0, input logic [31:0] s1,
                             input logic [9:0] exp_act, input int exp_fv);
    int bc, fc, fe;
    do_frame(s0, s1, bc, fc, fe);
    checks++;
    if (bc !== 8) begin failures++; $display("FAIL %s_busy cycles=%0d required=8", name, bc); end
    checks++;
    if (fc !== exp_fv || (exp_fv == 1 && fe !== 8)) begin
      failures++;
      $display("FAIL %s_frame_valid pulses=%0d at=%0d required %0d at 8", name, fc, fe, exp_fv);
    end
    checks++;
    if (actions !== exp_act) begin failures++; $display("FAIL %s_actions got=%h required=%h", name, actions, exp_act); end
    $display("%s: actions=%h busy_cycles=%0d fv_pulses=%0d", name, actions, bc, fc);
  endtask

  task automatic test_mapping();
    check_frame("p1_up_fire", 32'h0000_2C1A, 32'h0, 10'h011, 1);
    // 07->bit3, 04->bit1, 52->bit5, 4F->bit8, 16->bit2, 28->bit9
    check_frame("mixed", 32'h4F52_0407, 32'h0000_2816, 10'h32E, 1);
    // 1A->bit0, 50->bit6, 51->bit7, 2C->bit4; unmapped FF ignored
    check_frame("rest", 32'h2C51_501A, 32'h0000_00FF, 10'h0D1, 1);
  endtask

  task automatic test_abort();
    logic [31:0] r;
    check_frame("setup", 32'h0000_2C1A, 32'h0, 10'h011, 1);
    check_frame("abort", 32'h0000_0101, 32'h0, 10'h011, 0);
    av_read(2'd3, r);
    checks++;
    if (r[2] !== 1'b1 || r[19:10] !== 10'h011) begin
      failures++; $display("FAIL abort_err status=%h required err=1 actions=011", r);
    end
    av_write(2'd3, 32'h1);
    av_read(2'd3, r);
    checks++;
    if (r[2] !== 1'b0) begin failures++; $display("FAIL err_clear err=%b required=0", r[2]); end
    $display("test_abort: status=%h", r);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int fc;
    int fe [2];
    logic [9:0] fa [2];
    fc = 0; fe[0] = -1; fe[1] = -1; fa[0] = '0; fa[1] = '0;
    av_write(2'd0, 32'h0000_2C1A);
    av_write(2'd1, 32'h0);
    av_write(2'd2, 32'h0);      // E0
    step();                      // E1
    step();                      // E2
    av_write(2'd2, 32'h0);      // E3: queued
    av_read(2'd3, r);
    checks++;
    if (r[3] !== 1'b1) begin failures++; $display("FAIL pending_set pending=%b required=1", r[3]); end
    av_write(2'd0, 32'h0000_0050); // E4: staging only
    av_write(2'd2, 32'h0);      // E5: dropped
    for (int k = 5; k < 30; k++) begin
      if (frame_valid) begin
        if (fc < 2) begin fe[fc] = k; fa[fc] = actions; end
        fc++;
      end
      step();
    end
    checks++;
    if (fc !== 2) begin failures++; $display("FAIL b2b_frames count=%0d required=2", fc); end
    checks++;
    if (fe[0] !== 8 || fa[0] !== 10'h011) begin
      failures++; $display("FAIL b2b_first at=%0d actions=%h required 8/011", fe[0], fa[0]);
    end
    checks++;
    if (fe[1] !== 15 || fa[1] !== 10'h040) begin
      failures++; $display("FAIL b2b_second at=%0d actions=%h required 15/040", fe[1], fa[1]);
    end
    av_read(2'd3, r);
    checks++;
    if (r[3] !== 1'b0 || r[1] !== 1'b0) begin
      failures++; $display("FAIL b2b_idle status=%h required pending=0 busy=0", r);
    end
    $display("test_back_to_back: frames=%0d first=%h@%0d second=%h@%0d", fc, fa[0], fe[0], fa[1], fe[1]);
  endtask

  task automatic test_reset_mid_scan();
    int fc;
    fc = 0;
    av_write(2'd0, 32'h0000_2C1A);
    av_write(2'd2, 32'h0);      // E0
    step(); step(); step();      // after E3
    reset_n = 1'b0;
    #1;
    checks++;
    if (actions !== 10'd0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
      failures++; $display("FAIL midscan_reset actions=%h busy=%b fv=%b required 000/0/0", actions, busy, frame_valid);
    end
    step(); step();
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (frame_valid) fc++;
      step();
    end
    checks++;
    if (fc !== 0) begin failures++; $display("FAIL midscan_no_frame pulses=%0d required=0", fc); end
    $display("test_reset_mid_scan: pulses_after_reset=%0d", fc);
    check_frame("after_reset", 32'h0000_2C1A, 32'h0, 10'h011, 1);
  endtask

  task automatic test_release_and_map();
    logic [31:0] r;
    check_frame("release", 32'h0, 32'h0, 10'h000, 1);
    av_write(2'd1, 32'hFFFF_FFFF);
    av_read(2'd1, r);
    checks++;
    if (r !== 32'h0000_FFFF) begin failures++; $display("FAIL stage1_read got=%h required=0000ffff", r); end
    av_read(2'd2, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL addr2_read got=%h required=00000000", r); end
    $display("test_release_and_map: addr1 readback done");
  endtask

  initial begin
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mapping();
    test_abort();
    test_back_to_back();
    test_reset_mid_scan();
    test_release_and_map();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
